// File: rtl/music_pkg.sv
// Shared types and constants for the buzzer autoplay sequencer: FSM state
// encoding, note code type and the 50 MHz tone half-period table.
package music_pkg;

  localparam int NOTE_BITS = 5;
  localparam int TBL_W     = 18;

  typedef logic [NOTE_BITS-1:0] note_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    PAUSED,
    DONE
  } state_t;

  typedef logic [0:31][TBL_W-1:0] tone_tbl_t;

  localparam note_t REST = '0;

  // Half-periods in 50 MHz cycles; code 1 = C4, chromatic upward to F#6.
  localparam tone_tbl_t TONE_HALF = {
    18'd0,     18'd95556, 18'd90194, 18'd85133, 18'd80352, 18'd75843,
    18'd71586, 18'd67569, 18'd63776, 18'd60197, 18'd56818, 18'd53630,
    18'd50620, 18'd47778, 18'd45096, 18'd42566, 18'd40177, 18'd37921,
    18'd35793, 18'd33784, 18'd31888, 18'd30098, 18'd28409, 18'd26814,
    18'd25310, 18'd23889, 18'd22548, 18'd21283, 18'd20088, 18'd18961,
    18'd17897, 18'd16892
  };

endpackage

// File: rtl/music_sequencer_if.sv
// Control, status and note-ROM signals between the key/mode controller,
// the note ROM and the sequencer.
interface music_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int NOTE_W = 5
) ();
  import music_pkg::*;

  // No valid/ready here: play/pause/loop_en/tempo_sel are levels, restart is a
  // one-cycle pulse, and the ROM returns rom_data one cycle after rom_addr.
  logic              play;
  logic              pause;
  logic              restart;
  logic              loop_en;
  logic [1:0]        tempo_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] rom_data;
  logic              buzzer;
  logic              busy;
  logic              paused;
  logic              done;
  logic [ADDR_W-1:0] note_idx;
  state_t            state;

  modport master (
    output play, pause, restart, loop_en, tempo_sel, rom_data,
    input  rom_addr, buzzer, busy, paused, done, note_idx, state
  );

  modport slave (
    input  play, pause, restart, loop_en, tempo_sel, rom_data,
    output rom_addr, buzzer, busy, paused, done, note_idx, state
  );

endinterface

// File: rtl/music_sequencer_tone_gen.sv
// Square-wave tone generator: looks up the half-period of the current note and
// toggles the buzzer phase every half-period; phase-continuous across equal notes.
module tone_gen
  import music_pkg::*;
#(
  parameter int        HP_W     = 18,
  parameter tone_tbl_t HALF_TBL = TONE_HALF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  note_t cur_note_i,
  input  note_t next_note_i,
  input  logic  load_i,
  input  logic  freeze_i,
  input  logic  gap_i,
  output logic  buzzer_o
);

  logic [HP_W-1:0] half;
  logic [HP_W-1:0] tone_cnt_q, tone_cnt_d;
  logic            phase_q, phase_d;

  assign half = HP_W'(HALF_TBL[cur_note_i]);

  always_comb begin
    tone_cnt_d = tone_cnt_q;
    phase_d    = phase_q;
    if (load_i && (next_note_i != cur_note_i)) begin
      tone_cnt_d = '0;
      phase_d    = 1'b0;
    end else if ((cur_note_i == REST) || (half == '0)) begin
      tone_cnt_d = '0;
      phase_d    = 1'b0;
    end else if (freeze_i || gap_i) begin
      tone_cnt_d = tone_cnt_q;
    end else if (tone_cnt_q == half - HP_W'(1)) begin
      tone_cnt_d = '0;
      phase_d    = ~phase_q;
    end else begin
      tone_cnt_d = tone_cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Muting is combinational so pause/stop silence the pin on the same edge.
  assign buzzer_o = phase_q & ~freeze_i & ~gap_i;

endmodule

// File: rtl/music_sequencer.sv
// Autoplay sequencer: steps a registered note ROM at a selectable tempo and drives
// tone_gen. Define ARTIC_GAP_EN to silence the last beat_len>>3 cycles of each step.
module music_sequencer
  import music_pkg::*;
#(
  parameter int        BEAT_DIV = 9373830,
  parameter int        SONG_LEN = 357,
  parameter int        ADDR_W   = 9,
  parameter int        NOTE_W   = 5,
  parameter int        HP_W     = 18,
  parameter tone_tbl_t HALF_TBL = TONE_HALF
) (
  input logic              clk,
  input logic              rst_n,
  music_sequencer_if.slave sif
);

  localparam int                BEAT_W     = $clog2(BEAT_DIV + 1);
  localparam logic [BEAT_W-1:0] BEAT_DIV_W = BEAT_W'(BEAT_DIV);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(SONG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  note_t             cur_note_q, cur_note_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] beat_len_q, beat_len_d;
  logic              done_q, done_d;
  logic              load_en;
  logic              freeze;
  logic              gap;
  logic [NOTE_W-1:0] rom_note;

  assign rom_note = sif.rom_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      note_idx_q <= '0;
      cur_note_q <= REST;
      beat_cnt_q <= '0;
      beat_len_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      note_idx_q <= note_idx_d;
      cur_note_q <= cur_note_d;
      beat_cnt_q <= beat_cnt_d;
      beat_len_q <= beat_len_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    note_idx_d = note_idx_q;
    cur_note_d = cur_note_q;
    beat_cnt_d = beat_cnt_q;
    beat_len_d = beat_len_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    if (!sif.play) begin
      state_d    = IDLE;
      idx_d      = '0;
      note_idx_d = '0;
      cur_note_d = REST;
      beat_cnt_d = '0;
    end else if (sif.restart && (state_q != IDLE)) begin
      state_d = FETCH;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = LOAD;
        LOAD: begin
          load_en    = 1'b1;
          cur_note_d = note_t'(rom_note);
          note_idx_d = idx_q;
          beat_len_d = BEAT_DIV_W >> sif.tempo_sel;
          beat_cnt_d = '0;
          state_d    = sif.pause ? PAUSED : PLAY;
        end
        PLAY: begin
          if (sif.pause) begin
            state_d = PAUSED;
          end else if (beat_cnt_q == beat_len_q - BEAT_W'(1)) begin
            if (idx_q < LAST_IDX) begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = FETCH;
            end else if (sif.loop_en) begin
              idx_d   = '0;
              state_d = FETCH;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        PAUSED:  if (!sif.pause) state_d = PLAY;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The previous note keeps sounding through FETCH/LOAD of the next one.
  assign freeze = !(state_q inside {FETCH, LOAD, PLAY});

`ifdef ARTIC_GAP_EN
  assign gap = (state_q == PLAY) && (beat_cnt_q >= beat_len_q - (beat_len_q >> 3));
`else
  assign gap = 1'b0;
`endif

  tone_gen #(
    .HP_W     (HP_W),
    .HALF_TBL (HALF_TBL)
  ) u_tone_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .cur_note_i  (cur_note_q),
    .next_note_i (note_t'(rom_note)),
    .load_i      (load_en),
    .freeze_i    (freeze),
    .gap_i       (gap),
    .buzzer_o    (sif.buzzer)
  );

  assign sif.rom_addr = idx_q;
  assign sif.busy     = state_q inside {FETCH, LOAD, PLAY, PAUSED};
  assign sif.paused   = (state_q == PAUSED);
  assign sif.done     = done_q;
  assign sif.note_idx = note_idx_q;
  assign sif.state    = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer with a 4-entry stub ROM {17,0,17,20}, BEAT_DIV=16
// and half-periods 3 (code 17) and 2 (code 20).
module tb_music_sequencer;
  import music_pkg::*;

  localparam int BEAT_DIV = 16;
  localparam int SONG_LEN = 4;
  localparam int ADDR_W   = 9;
  localparam int NOTE_W   = 5;
  localparam int HP_W     = 18;
  localparam int W        = 27;

`ifdef ARTIC_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  function automatic tone_tbl_t tb_tbl();
    tone_tbl_t t;
    t     = TONE_HALF;
    t[17] = 18'd3;
    t[20] = 18'd2;
    return t;
  endfunction

  localparam tone_tbl_t TB_TBL = tb_tbl();

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  int                cyc   = 0;
  int                checks   = 0;
  int                failures = 0;
  logic [W-1:0]      exp_q[$];
  logic              sb_en    = 1'b0;
  logic [ADDR_W-1:0] prev_idx = '0;
  logic [NOTE_W-1:0] rom [0:3];
  logic              mon_hit;
  logic [W-1:0]      mon_got, mon_want;

  music_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) sif ();

  music_sequencer #(
    .BEAT_DIV (BEAT_DIV),
    .SONG_LEN (SONG_LEN),
    .ADDR_W   (ADDR_W),
    .NOTE_W   (NOTE_W),
    .HP_W     (HP_W),
    .HALF_TBL (TB_TBL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  // ---------------- clock / reset / stub ROM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sif.rom_data <= rom[sif.rom_addr[1:0]];

  // ---------------- scoreboard monitor ----------------
  // Events: tag 0 = note_idx changed, tag 1 = done high; keyed by edge number.
  function automatic logic [W-1:0] ev(int tag, int c, int v);
    return {2'(tag), 16'(c), 9'(v)};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_hit = (k == 0) ? (sif.note_idx !== prev_idx) : (sif.done === 1'b1);
      mon_got = (k == 0) ? ev(0, cyc, int'(sif.note_idx)) : ev(1, cyc, 1);
      if (sb_en && mon_hit) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_event unexpected got=%h want=none", mon_got);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            failures++;
            $display("FAIL sb_event got=%h want=%h", mon_got, mon_want);
          end
        end
      end
    end
    prev_idx = sif.note_idx;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stop_song();
    sif.play    = 1'b0;
    sif.pause   = 1'b0;
    sif.restart = 1'b0;
    tick();
    tick();
  endtask

  task automatic sb_close(input string name);
    @(negedge clk);
    #1;
    sb_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover got=%0d pending want=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Expected buzzer for the plain 16-cycle song, c = edges since play rose.
  function automatic logic exp_buzz(int c);
    int k, j, eff, half;
    logic [NOTE_W-1:0] code;
    if (c < 3 || c >= 73) return 1'b0;
    k    = (c - 3) / 18;
    j    = (c - 3) % 18;
    code = rom[k];
    half = (code == 5'd17) ? 3 : (code == 5'd20) ? 2 : 0;
    if (half == 0) return 1'b0;
    if (GAP_ON && (j == 14 || j == 15)) return 1'b0;
    eff = (GAP_ON && j >= 16) ? j - 2 : j;
    return 1'((eff / half) % 2);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 7;
    if (sif.buzzer !== 1'b0)   begin failures++; $display("FAIL reset_buzzer got=%b want=0", sif.buzzer); end
    if (sif.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b want=0", sif.busy); end
    if (sif.paused !== 1'b0)   begin failures++; $display("FAIL reset_paused got=%b want=0", sif.paused); end
    if (sif.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b want=0", sif.done); end
    if (sif.note_idx !== '0)   begin failures++; $display("FAIL reset_note_idx got=%0d want=0", sif.note_idx); end
    if (sif.rom_addr !== '0)   begin failures++; $display("FAIL reset_rom_addr got=%0d want=0", sif.rom_addr); end
    if (sif.state !== IDLE)    begin failures++; $display("FAIL reset_state got=%0d want=%0d", sif.state, IDLE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_play();
    int n0;
    stop_song();
    n0 = cyc;
    exp_q.push_back(ev(0, n0 + 21, 1));
    exp_q.push_back(ev(0, n0 + 39, 2));
    exp_q.push_back(ev(0, n0 + 57, 3));
    exp_q.push_back(ev(1, n0 + 73, 1));
    sb_en    = 1'b1;
    sif.play = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      checks++;
      if (sif.buzzer !== exp_buzz(c)) begin
        failures++;
        $display("FAIL basic_buzzer cyc=%0d got=%b want=%b", c, sif.buzzer, exp_buzz(c));
      end
      if (c == 72 || c == 73) begin
        checks++;
        if (sif.busy !== (c == 72)) begin
          failures++;
          $display("FAIL basic_busy cyc=%0d got=%b want=%b", c, sif.busy, (c == 72));
        end
      end
    end
    sb_close("basic");
  endtask

  task automatic test_loop();
    int n0;
    stop_song();
    n0 = cyc;
    for (int k = 1; k <= 10; k++) exp_q.push_back(ev(0, n0 + 3 + 18 * k, k % 4));
    sb_en       = 1'b1;
    sif.loop_en = 1'b1;
    sif.play    = 1'b1;
    repeat (200) tick();
    checks++;
    if (sif.busy !== 1'b1) begin failures++; $display("FAIL loop_busy got=%b want=1", sif.busy); end
    sb_close("loop");
    sif.loop_en = 1'b0;
  endtask

  task automatic test_tempo();
    int n0;
    stop_song();
    sif.tempo_sel = 2'd2;
    n0 = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(ev(0, n0 + 3 + 6 * k, k));
    exp_q.push_back(ev(1, n0 + 25, 1));
    sb_en    = 1'b1;
    sif.play = 1'b1;
    repeat (30) tick();
    checks++;
    if (sif.busy !== 1'b0) begin failures++; $display("FAIL tempo_busy got=%b want=0", sif.busy); end
    sb_close("tempo");
    sif.tempo_sel = 2'd0;
  endtask

  task automatic test_pause();
    int n0;
    stop_song();
    n0 = cyc;
    exp_q.push_back(ev(0, n0 + 42, 1));
    sb_en    = 1'b1;
    sif.play = 1'b1;
    repeat (10) tick();
    sif.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sif.paused !== 1'b1 || sif.buzzer !== 1'b0 || sif.busy !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold i=%0d got paused=%b buzzer=%b busy=%b want 1/0/1",
                 i, sif.paused, sif.buzzer, sif.busy);
      end
    end
    sif.pause = 1'b0;
    tick();
    checks++;
    if (sif.paused !== 1'b0 || sif.buzzer !== 1'b0) begin
      failures++;
      $display("FAIL pause_resume got paused=%b buzzer=%b want 0/0", sif.paused, sif.buzzer);
    end
    tick();
    checks++;
    if (sif.buzzer !== 1'b1) begin failures++; $display("FAIL pause_tone_phase got=%b want=1", sif.buzzer); end
    repeat (12) tick();
    sb_close("pause");
  endtask

  task automatic test_restart_stop();
    stop_song();
    sif.play = 1'b1;
    repeat (25) tick();
    sif.pause = 1'b1;
    tick();
    tick();
    checks++;
    if (sif.paused !== 1'b1 || sif.rom_addr !== 9'd1) begin
      failures++;
      $display("FAIL restart_pre got paused=%b rom_addr=%0d want 1/1", sif.paused, sif.rom_addr);
    end
    sif.restart = 1'b1;
    tick();
    sif.restart = 1'b0;
    checks++;
    if (sif.state !== FETCH || sif.rom_addr !== 9'd0 || sif.paused !== 1'b0) begin
      failures++;
      $display("FAIL restart_fetch got state=%0d rom_addr=%0d paused=%b want %0d/0/0",
               sif.state, sif.rom_addr, sif.paused, FETCH);
    end
    tick();
    tick();
    checks++;
    if (sif.paused !== 1'b1 || sif.note_idx !== 9'd0) begin
      failures++;
      $display("FAIL load_then_pause got paused=%b note_idx=%0d want 1/0", sif.paused, sif.note_idx);
    end
    sif.pause = 1'b0;
    repeat (4) tick();
    checks++;
    if (sif.buzzer !== 1'b1) begin failures++; $display("FAIL restart_tone got=%b want=1", sif.buzzer); end
    sif.play = 1'b0;
    tick();
    checks++;
    if (sif.state !== IDLE || sif.buzzer !== 1'b0 || sif.note_idx !== 9'd0 || sif.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop got state=%0d buzzer=%b note_idx=%0d busy=%b want %0d/0/0/0",
               sif.state, sif.buzzer, sif.note_idx, sif.busy, IDLE);
    end
  endtask

  task automatic test_reset_mid_play();
    stop_song();
    sif.play = 1'b1;
    repeat (43) tick();
    checks++;
    if (sif.buzzer !== 1'b1 || sif.note_idx !== 9'd2) begin
      failures++;
      $display("FAIL midplay_pre got buzzer=%b note_idx=%0d want 1/2", sif.buzzer, sif.note_idx);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (sif.buzzer !== 1'b0 || sif.busy !== 1'b0 || sif.paused !== 1'b0 || sif.done !== 1'b0 ||
        sif.note_idx !== '0 || sif.rom_addr !== '0 || sif.state !== IDLE) begin
      failures++;
      $display("FAIL midplay_reset got buzzer=%b busy=%b paused=%b done=%b note_idx=%0d rom_addr=%0d state=%0d want all 0/IDLE",
               sif.buzzer, sif.busy, sif.paused, sif.done, sif.note_idx, sif.rom_addr, sif.state);
    end
    sif.play = 1'b0;
    rst_n    = 1'b1;
    tick();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rom[0] = 5'd17;
    rom[1] = 5'd0;
    rom[2] = 5'd17;
    rom[3] = 5'd20;
    sif.play      = 1'b0;
    sif.pause     = 1'b0;
    sif.restart   = 1'b0;
    sif.loop_en   = 1'b0;
    sif.tempo_sel = 2'd0;
    test_reset();
    test_basic_play();
    test_loop();
    test_tempo();
    test_pause();
    test_restart_stop();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
